memory_interface: RTL and testbench
===================================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles to wait for mem_ack (used only when MEM_IF_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 Address  input  32  byte address of the access, from the MA mux (PC or RZ).
REQ-005 RM  input  32  store data.
REQ-006 MEM_read  input  1  level request for a read, from the control signal generator.
REQ-007 MEM_write  input  1  level request for a write, from the control signal generator.
REQ-008 Data  output  32  memory data register (MDR); feeds the IR load and the write-back path.
REQ-009 MFC  output  1  memory function complete; one-cycle pulse.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 bus_err  output  1  one-cycle pulse with MFC when an access fails.
REQ-012 mem_addr  output  32  word address to memory, {Address[31:2], 2'b00} as latched.
REQ-013 mem_wdata  output  32  latched store data.
REQ-014 mem_req / mem_we  output  1 each  bus request and write strobe.
REQ-015 mem_rdata  input  32, and mem_ack  input  1  read data and completion from memory.

Function
REQ-016 FSM states SHALL be IDLE, BUS, DONE and HOLD.
REQ-017 IDLE: when exactly one of MEM_read or MEM_write is high, the block SHALL latch Address, RM and the op, then go to BUS on the next edge.
REQ-018 IDLE with MEM_read and MEM_write both high SHALL start no bus cycle, go to DONE and pulse bus_err with MFC.
REQ-019 BUS: mem_req SHALL be high and mem_we SHALL equal the latched op; mem_addr and mem_wdata SHALL be held stable.
REQ-020 BUS with mem_ack high: on a read, Data SHALL load mem_rdata on that edge; mem_req SHALL drop; the next state SHALL be DONE.
REQ-021 A write SHALL leave Data unchanged.
REQ-022 mem_ack outside BUS SHALL be ignored.
REQ-023 DONE SHALL assert MFC for exactly one cycle, then go to HOLD.
REQ-024 HOLD SHALL remain until MEM_read and MEM_write are both low, then go to IDLE, so a held request never runs twice.
REQ-025 Minimum latency SHALL be: request seen in IDLE at edge N, mem_req high in cycle N+1, ack at edge N+1, MFC high in cycle N+2.
REQ-026 Address[1:0] SHALL be ignored (word accesses only).
REQ-027 Data SHALL hold its value between reads.

Reset
REQ-028 While reset_n is low, state SHALL be IDLE and Data, mem_addr and mem_wdata SHALL be 0.
REQ-029 While reset_n is low, MFC, busy, bus_err, mem_req and mem_we SHALL be 0.
REQ-030 A reset asserted during BUS SHALL abort the access immediately, with no MFC.

Configuration
REQ-031 With MEM_IF_TIMEOUT_EN defined, a counter SHALL clear on entry to BUS and count each BUS cycle without ack.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES, mem_req SHALL drop, Data SHALL be unchanged, and the block SHALL go to DONE with bus_err pulsed.
REQ-033 Without MEM_IF_TIMEOUT_EN, BUS SHALL wait for mem_ack indefinitely, no counter logic SHALL exist, and bus_err SHALL come only from REQ-018.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2-bit), the word width 32 and the default timeout constant.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-036 Read with zero wait: Address=0x00000104, MEM_read high, ack in the first BUS cycle with rdata=0xDEADBEEF -> mem_addr=0x104, Data=0xDEADBEEF, MFC high exactly 2 cycles after the request, one pulse only.
REQ-037 Write with 3 wait cycles: Address=0x00000203, RM=0x12345678 -> mem_addr=0x200, mem_we=1, mem_wdata=0x12345678 for 4 cycles, MFC once, Data unchanged.
REQ-038 MEM_read held high for 10 cycles after MFC -> exactly one bus cycle; IDLE reached only after MEM_read falls.
REQ-039 MEM_read and MEM_write both high -> no mem_req, MFC and bus_err pulse together.
REQ-040 With MEM_IF_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no ack -> mem_req drops after 4 cycles, MFC and bus_err pulse, Data keeps its old value.
REQ-041 reset_n pulled low mid-BUS -> all outputs 0 asynchronously, no MFC, next request served normally.

Source files
------------

// File: rtl/memory_interface_pkg.sv
// Shared definitions for memory_interface: FSM state encoding, data word
// width and the default bus timeout.
package memory_interface_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/memory_interface.sv
// memory_interface: turns level MEM_read / MEM_write requests from the control
// unit into a single handshaked word access on the memory bus, keeps the read
// result in the MDR (Data) and signals completion with a one-cycle MFC pulse.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   Address, RM              byte address and store data of the access
//   MEM_read, MEM_write      level requests (both high is an illegal request)
//   Data                     memory data register, loaded by reads only
//   MFC, bus_err             completion pulse and error pulse (error rides MFC)
//   busy                     high whenever the FSM is not idle
//   mem_addr, mem_wdata      latched word address and store data
//   mem_req, mem_we          bus request and write strobe
//   mem_rdata, mem_ack       read data and completion from memory
//
// Build option: MEM_IF_TIMEOUT_EN adds a bus watchdog that abandons an access
// after TIMEOUT_CYCLES cycles without mem_ack and reports bus_err.
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] Address,
    input  logic [WORD_W-1:0] RM,
    input  logic              MEM_read,
    input  logic              MEM_write,
    output logic [WORD_W-1:0] Data,
    output logic              MFC,
    output logic              busy,
    output logic              bus_err,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              op_q, op_d;       // 1 = write
    logic              err_q, err_d;     // pending error for the DONE pulse
    logic              mfc_q, mfc_d;
    logic              busy_q, busy_d;
    logic              berr_q, berr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;

    // Byte offset is not used: accesses are always whole words.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = Address[1:0];

`ifdef MEM_IF_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
            mfc_q   <= mfc_d;
            busy_q  <= busy_d;
            berr_q  <= berr_d;
            req_q   <= req_d;
            we_q    <= we_d;
`ifdef MEM_IF_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // registered and line up with the state they describe.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        err_d   = err_q;
`ifdef MEM_IF_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (MEM_read && MEM_write) begin
                    // Conflicting request: report it without touching the bus.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (MEM_read || MEM_write) begin
                    addr_d  = {Address[WORD_W-1:2], 2'b00};
                    wdata_d = RM;
                    op_d    = MEM_write;
                    err_d   = 1'b0;
                    state_d = ST_BUS;
`ifdef MEM_IF_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    if (!op_q) begin
                        data_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end
`ifdef MEM_IF_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for the request to go away so it is not served twice.
                if (!MEM_read && !MEM_write) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_BUS);
        we_d   = req_d && op_d;
        mfc_d  = (state_d == ST_DONE);
        berr_d = mfc_d && err_d;
    end

    assign Data      = data_q;
    assign MFC       = mfc_q;
    assign busy      = busy_q;
    assign bus_err   = berr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;

endmodule

// File: tb/tb_memory_interface.sv
// Testbench for memory_interface: a driver issues requests and queues the
// expected bus cycle and completion; a memory responder checks every bus
// cycle and acks after a chosen delay; a monitor checks each MFC.
module tb_memory_interface;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset_n;
    logic [31:0] Address;
    logic [31:0] RM;
    logic        MEM_read;
    logic        MEM_write;
    logic [31:0] Data;
    logic        MFC;
    logic        busy;
    logic        bus_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    memory_interface #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Address   (Address),
        .RM        (RM),
        .MEM_read  (MEM_read),
        .MEM_write (MEM_write),
        .Data      (Data),
        .MFC       (MFC),
        .busy      (busy),
        .bus_err   (bus_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        int          wt;
        bit          no_ack;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } cmp_t;

    bus_t        bus_q[$];
    cmp_t        cmp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_data;   // MDR contents the design should hold

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_Data"},      Data, 32'h0);
        chk({tag, "_MFC"},       32'(MFC), 32'h0);
        chk({tag, "_busy"},      32'(busy), 32'h0);
        chk({tag, "_bus_err"},   32'(bus_err), 32'h0);
        chk({tag, "_mem_addr"},  mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_req"},   32'(mem_req), 32'h0);
        chk({tag, "_mem_we"},    32'(mem_we), 32'h0);
    endtask

    // Monitor: every MFC must match the oldest queued completion.
    initial begin : monitor
        cmp_t c;
        logic mfc_prev;
        mfc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_err && !MFC) chk("bus_err_without_mfc", 32'(MFC), 32'h1);
            if (MFC) begin
                chk("mfc_single_pulse", 32'(mfc_prev), 32'h0);
                if (cmp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mfc: got MFC=1 expected no completion at %0t", $time);
                end else begin
                    c = cmp_q.pop_front();
                    chk("bus_err", 32'(bus_err), 32'(c.err));
                    chk("data", Data, c.data);
                end
            end
            mfc_prev = MFC;
        end
    end

    // Memory responder: checks each bus cycle against the queued access and
    // acks after the chosen number of wait cycles; stray acks elsewhere.
    initial begin : responder
        bus_t cur;
        int   cnt;
        bit   in_bus;
        in_bus    = 1'b0;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (in_bus && !mem_req) begin
                if (!cur.no_ack) begin
                    checks++;
                    errors++;
                    $display("FAIL req_dropped_early: got mem_req=0 expected 1 at %0t", $time);
                end
                in_bus = 1'b0;
            end
            if (mem_req && !in_bus) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got mem_req=1 expected 0 at %0t", $time);
                    cur.no_ack = 1'b1;
                    cur.addr   = mem_addr;
                    cur.wdata  = mem_wdata;
                    cur.we     = mem_we;
                    cur.wt     = 0;
                end else begin
                    cur = bus_q.pop_front();
                end
                in_bus = 1'b1;
                cnt    = 0;
            end
            if (in_bus) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                if (!cur.no_ack && cnt == cur.wt) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rdata;
                    in_bus    = 1'b0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    cnt++;
                end
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // One request from issue to return-to-idle; called at a negedge.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] rm, input logic [31:0] rdata,
                          input int wt, input int hold, input bit no_ack);
        cmp_t c;
        bus_t b;
        int   exp_lat;
        int   lat;
        bit   got;
        int   hn;
        if (rd && wr) begin
            c.err   = 1'b1;
            c.data  = model_data;
            exp_lat = 1;
        end else begin
            b.addr   = {addr[31:2], 2'b00};
            b.wdata  = rm;
            b.we     = wr;
            b.rdata  = rdata;
            b.wt     = wt;
            b.no_ack = no_ack;
            bus_q.push_back(b);
            if (no_ack) begin
                c.err   = 1'b1;
                c.data  = model_data;
                exp_lat = TO + 1;
            end else begin
                if (rd) model_data = rdata;
                c.err   = 1'b0;
                c.data  = model_data;
                exp_lat = wt + 2;
            end
        end
        cmp_q.push_back(c);

        MEM_read  = rd;
        MEM_write = wr;
        Address   = addr;
        RM        = rm;

        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (MFC) got = 1'b1;
        end
        chk("mfc_latency", 32'(lat), 32'(exp_lat));

        // Request stays up: the block must sit in HOLD without a second access.
        hn = (hold < 1) ? 1 : hold;
        for (int i = 0; i < hn; i++) begin
            @(negedge clk);
            chk("busy_in_hold", 32'(busy), 32'h1);
            chk("no_req_in_hold", 32'(mem_req), 32'h0);
        end
        MEM_read  = 1'b0;
        MEM_write = 1'b0;
        Address   = $urandom;
        RM        = $urandom;
        @(negedge clk);
        chk("idle_after_release", 32'(busy), 32'h0);
    endtask

    initial begin : main
        int lat;
        bus_t b;
        reset_n    = 1'b0;
        MEM_read   = 1'b0;
        MEM_write  = 1'b0;
        Address    = 32'h0;
        RM         = 32'h0;
        model_data = 32'h0;

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Zero-wait read, 3-wait write, held read, conflicting request.
        do_txn(1'b1, 1'b0, 32'h0000_0104, $urandom, 32'hDEAD_BEEF, 0, 1, 1'b0);
        do_txn(1'b0, 1'b1, 32'h0000_0203, 32'h1234_5678, $urandom, 3, 1, 1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_3001, $urandom, 32'hCAFE_F00D, 1, 10, 1'b0);
        do_txn(1'b1, 1'b1, 32'h0000_0500, $urandom, $urandom, 0, 2, 1'b0);
`ifdef MEM_IF_TIMEOUT_EN
        do_txn(1'b1, 1'b0, 32'h0000_0600, $urandom, $urandom, 0, 1, 1'b1);
`endif

        // Reset in the middle of a bus cycle that never gets an ack.
        b.addr   = 32'h0000_0450;
        b.wdata  = 32'h0;
        b.rdata  = 32'h0;
        b.we     = 1'b0;
        b.wt     = 0;
        b.no_ack = 1'b1;
        bus_q.push_back(b);
        MEM_read = 1'b1;
        Address  = 32'h0000_0452;
        lat = 0;
        while (!mem_req && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("reset_test_req_seen", 32'(mem_req), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        MEM_read   = 1'b0;
        model_data = 32'h0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'h0);

        // Randomized mix of reads, writes and conflicting requests.
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 9);
            do_txn((k == 0) || (k < 5), (k == 0) || (k >= 5), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(bus_q.size() + cmp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
